uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// FSM state encoding and the WAIT_LOW timeout length.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } arb_state_t;

  localparam int WAIT_LOW_TIMEOUT = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after (i_last + 1) mod NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_index
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int                 sum;
    logic [IDX_W-1:0]   idx;
    o_found = 1'b0;
    o_index = '0;
    sum     = 0;
    idx     = '0;
    // Walk from farthest to nearest so the nearest requester overwrites last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = int'(i_last) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      idx = sum[IDX_W-1:0];
      if (i_req[idx]) begin
        o_found = 1'b1;
        o_index = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ cores.
// Define UART_ARB_LOCK_EN to let req_lock keep ownership across a message.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_byte,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            ack,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  input  logic                          tx_ready,
  output logic                          txByteStart,
  output logic [DATA_WIDTH-1:0]         byteForTx
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WAIT_LOW_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LOW_TIMEOUT - 1);

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       r_last;
  logic [DATA_WIDTH-1:0]  r_byte;
  logic                   r_busy;
  logic                   r_start;
  logic [NUM_REQ-1:0]     r_ack;
  logic [CNT_W-1:0]       r_wl_cnt;

  logic [NUM_REQ-1:0]     w_eligible;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;
  logic [NUM_REQ-1:0]     w_pick_onehot;
  logic [DATA_WIDTH-1:0]  w_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_bytes[gi]       = req_byte[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_pick_onehot[gi] = (w_pick == IDX_W'(gi));
    end
  endgenerate

`ifdef UART_ARB_LOCK_EN
  logic               r_lock_hold;
  logic [NUM_REQ-1:0] w_owner_onehot;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign w_owner_onehot[gi] = (r_owner == IDX_W'(gi));
    end
  endgenerate

  // Lock is captured when a frame completes; releasing req_lock reopens
  // round-robin immediately, starting after the current owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_hold <= 1'b0;
    end else if (r_state == WAIT_HIGH && tx_ready) begin
      r_lock_hold <= req_lock[r_owner];
    end else if (r_state == WAIT_LOW && tx_ready && r_wl_cnt == CNT_LAST) begin
      r_lock_hold <= 1'b0;
    end
  end

  assign w_eligible = (r_lock_hold && req_lock[r_owner]) ? (req & w_owner_onehot) : req;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_eligible    = req;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (w_eligible),
    .i_last  (r_last),
    .o_found (w_found),
    .o_index (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_byte   <= '0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_ack    <= '0;
      r_wl_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_ready && w_found) begin
            r_state <= START;
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_byte  <= w_bytes[w_pick];
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_ack   <= w_pick_onehot;
          end
        end
        START: begin
          r_start  <= 1'b0;
          r_ack    <= '0;
          r_wl_cnt <= '0;
          r_state  <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // A UART that never drops ready is assumed to have already finished.
          if (!tx_ready) begin
            r_state <= WAIT_HIGH;
          end else if (r_wl_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_wl_cnt <= r_wl_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (tx_ready) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign owner       = r_owner;
  assign busy        = r_busy;
  assign txByteStart = r_start;
  assign byteForTx   = r_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: behavioural cores and UART model,
// expected grants queued per scenario and checked at each txByteStart.
module tb_uart_tx_arbiter;

  localparam int FRAME      = 10;
  localparam int MODE_AUTO  = 0;
  localparam int MODE_LOW   = 1;
  localparam int MODE_HIGH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req, req_lock, ack;
  logic [31:0] req_byte;
  logic [1:0]  owner;
  logic        busy, tx_ready, txByteStart;
  logic [7:0]  byteForTx;

  int compared   = 0;
  int mismatched = 0;
  int mode       = MODE_AUTO;
  int start_count = 0;
  int model_cnt  = 0;
  int ack_cnt [4] = '{default: 0};
  int rem     [4] = '{default: 0};
  logic [7:0] cbyte   [4] = '{default: 8'h00};
  logic       lock_en [4] = '{default: 1'b0};

  typedef struct packed {
    logic [1:0] core;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_byte    (req_byte),
    .req_lock    (req_lock),
    .ack         (ack),
    .owner       (owner),
    .busy        (busy),
    .tx_ready    (tx_ready),
    .txByteStart (txByteStart),
    .byteForTx   (byteForTx)
  );

  // Cores: hold req until ack, then advance to the next byte.
  initial begin
    req = '0; req_byte = '0; req_lock = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ack[i] === 1'b1 && rem[i] > 0) begin
          rem[i]--;
          cbyte[i] += 8'h11;
        end
        req[i]          = (rem[i] > 0);
        req_byte[i*8 +: 8] = cbyte[i];
        req_lock[i]     = lock_en[i] && (rem[i] > 0);
      end
    end
  end

  // UART model: drops ready for FRAME cycles after each start pulse.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mode == MODE_LOW) begin
        tx_ready = 1'b0; model_cnt = 0;
      end else if (mode == MODE_HIGH) begin
        tx_ready = 1'b1; model_cnt = 0;
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) tx_ready = 1'b1;
      end else if (txByteStart === 1'b1) begin
        tx_ready = 1'b0; model_cnt = FRAME;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Grant monitor: pops the scoreboard on every start pulse.
  initial begin
    exp_t e;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (txByteStart === 1'b1) begin
        start_count++;
        if (prev_start) begin
          compared++; mismatched++;
          $display("FAIL start_width: txByteStart high 2 cycles, required 1");
        end
        for (int i = 0; i < 4; i++) ack_cnt[i] += int'(ack[i]);
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_grant: owner=%0d byte=%h, required no grant", owner, byteForTx);
        end else begin
          e = sb.pop_front();
          compared++;
          if (owner !== e.core) begin
            mismatched++;
            $display("FAIL grant_owner: got %0d required %0d", owner, e.core);
          end
          compared++;
          if (byteForTx !== e.data) begin
            mismatched++;
            $display("FAIL grant_byte: got %h required %h", byteForTx, e.data);
          end
          compared++;
          if (ack !== (4'(1) << e.core)) begin
            mismatched++;
            $display("FAIL grant_ack: got %b required %b", ack, 4'(1) << e.core);
          end
          $display("grant core=%0d byte=%h ack=%b", owner, byteForTx, ack);
        end
      end else if (ack !== 4'b0000) begin
        compared++; mismatched++;
        $display("FAIL stray_ack: got %b required 0000", ack);
      end
      prev_start = (txByteStart === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int c, input logic [7:0] d);
    exp_t e;
    e.core = 2'(c);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic clear_cores();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; lock_en[i] = 1'b0; ack_cnt[i] = 0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 600) begin
      @(posedge clk); #2; n++;
    end
    compared++;
    if (n >= 600) begin
      mismatched++;
      $display("FAIL %s_drain: %0d grants outstanding, busy=%b, required 0 and 0", name, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (busy !== 1'b0)          begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
    compared++; if (txByteStart !== 1'b0)   begin mismatched++; $display("FAIL reset_start: got %b required 0", txByteStart); end
    compared++; if (ack !== 4'b0000)        begin mismatched++; $display("FAIL reset_ack: got %b required 0000", ack); end
    compared++; if (byteForTx !== 8'h00)    begin mismatched++; $display("FAIL reset_byte: got %h required 00", byteForTx); end
    compared++; if (owner !== 2'd0)         begin mismatched++; $display("FAIL reset_owner: got %0d required 0", owner); end
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic test_single();
    mode = MODE_AUTO;
    cbyte[0] = 8'hA5;
    push_exp(0, 8'hA5);
    rem[0] = 1;
    @(negedge clk);
    compared++; if (txByteStart !== 1'b0) begin mismatched++; $display("FAIL single_early: got %b required 0", txByteStart); end
    @(negedge clk);
    compared++; if (txByteStart !== 1'b1) begin mismatched++; $display("FAIL single_latency: got %b required 1", txByteStart); end
    compared++; if (ack !== 4'b0001)      begin mismatched++; $display("FAIL single_ack: got %b required 0001", ack); end
    wait_drain("single");
    compared++; if (byteForTx !== 8'hA5)  begin mismatched++; $display("FAIL single_hold_byte: got %h required a5", byteForTx); end
    compared++; if (owner !== 2'd0)       begin mismatched++; $display("FAIL single_hold_owner: got %0d required 0", owner); end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    clear_cores();
    for (int i = 0; i < 4; i++) cbyte[i] = 8'h30 + 8'(i);
    push_exp(0, 8'h30); push_exp(1, 8'h31); push_exp(2, 8'h32);
    push_exp(3, 8'h33); push_exp(0, 8'h41);
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    wait_drain("rr");
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (ack_cnt[i] !== ((i == 0) ? 2 : 1)) begin
        mismatched++;
        $display("FAIL rr_ack_count core %0d: got %0d required %0d", i, ack_cnt[i], (i == 0) ? 2 : 1);
      end
    end
  endtask

  task automatic test_not_ready();
    logic [1:0] own0;
    logic [7:0] byte0;
    int sc;
    clear_cores();
    mode = MODE_LOW;
    repeat (2) @(posedge clk); #2;
    own0 = owner; byte0 = byteForTx; sc = start_count;
    cbyte[2] = 8'hC2;
    push_exp(2, 8'hC2);
    rem[2] = 1;
    repeat (100) @(posedge clk); #2;
    compared++; if (start_count !== sc)  begin mismatched++; $display("FAIL notready_start: got %0d pulses required 0", start_count - sc); end
    compared++; if (busy !== 1'b0)       begin mismatched++; $display("FAIL notready_busy: got %b required 0", busy); end
    compared++; if (owner !== own0)      begin mismatched++; $display("FAIL notready_owner: got %0d required %0d", owner, own0); end
    compared++; if (byteForTx !== byte0) begin mismatched++; $display("FAIL notready_byte: got %h required %h", byteForTx, byte0); end
    mode = MODE_AUTO;
    repeat (2) @(posedge clk); #2;
    compared++; if (start_count !== sc + 1) begin mismatched++; $display("FAIL ready_grant_latency: got %0d pulses required 1", start_count - sc); end
    wait_drain("notready");
  endtask

  task automatic test_lock();
    pulse_reset();
    clear_cores();
    cbyte[0] = 8'h50; cbyte[1] = 8'h60;
`ifdef UART_ARB_LOCK_EN
    push_exp(0, 8'h50); push_exp(0, 8'h61); push_exp(0, 8'h72);
    push_exp(1, 8'h60); push_exp(1, 8'h71);
`else
    push_exp(0, 8'h50); push_exp(1, 8'h60); push_exp(0, 8'h61);
    push_exp(1, 8'h71); push_exp(0, 8'h72);
`endif
    lock_en[0] = 1'b1;
    rem[0] = 3; rem[1] = 2;
    wait_drain("lock");
    lock_en[0] = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int sc;
    pulse_reset();
    clear_cores();
    cbyte[1] = 8'h81;
    push_exp(1, 8'h81);
    rem[1] = 1;
    while (txByteStart !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    compared++; if (n >= 20) begin mismatched++; $display("FAIL midreset_first_grant: no start within 20 cycles"); end
    repeat (4) @(posedge clk); #2;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL midreset_busy_before: got %b required 1", busy); end
    cbyte[0] = 8'h90; cbyte[2] = 8'hA0;
    push_exp(0, 8'h90); push_exp(1, 8'h92); push_exp(2, 8'hA0);
    rem[0] = 1; rem[1] = 1; rem[2] = 1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compared++; if (busy !== 1'b0)        begin mismatched++; $display("FAIL midreset_busy: got %b required 0", busy); end
    compared++; if (txByteStart !== 1'b0) begin mismatched++; $display("FAIL midreset_start: got %b required 0", txByteStart); end
    @(posedge clk); #2 rst = 1'b0;
    sc = start_count;
    n = 0;
    while (tx_ready !== 1'b1 && n < 40) begin @(posedge clk); #2; n++; end
    compared++; if (start_count !== sc) begin mismatched++; $display("FAIL midreset_wait_ready: got %0d grants before ready required 0", start_count - sc); end
    wait_drain("midreset");
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_cores();
    mode = MODE_HIGH;
    cbyte[3] = 8'hD3;
    push_exp(3, 8'hD3);
    rem[3] = 1;
    while (txByteStart !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    compared++; if (n >= 20) begin mismatched++; $display("FAIL timeout_grant: no start within 20 cycles"); end
    repeat (4) @(posedge clk); #2;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL timeout_busy_early: got %b required 1", busy); end
    @(posedge clk); #2;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL timeout_busy_clear: got %b required 0", busy); end
    mode = MODE_AUTO;
    wait_drain("timeout");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_not_ready();
    test_lock();
    test_reset_midframe();
    test_timeout();
    repeat (5) @(posedge clk); #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty: %0d grants outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
